// File: rtl/mcs4_pkg.sv
// Shared MCS-4 bus types: instruction-cycle phases, I/O OPA codes and RAM-side op kinds.
// OPA decode takes the WMP enable as an argument so callers choose it via MCS4_RAM_OUTPORT_EN.
package mcs4_pkg;

    typedef enum logic [3:0] {
        PH_IDLE,
        PH_A1,
        PH_A2,
        PH_A3,
        PH_M1,
        PH_M2,
        PH_X1,
        PH_X2,
        PH_X3
    } phase_t;

    typedef enum logic [2:0] {
        OP_NONE,
        OP_WR_MAIN,
        OP_WR_STAT,
        OP_WR_PORT,
        OP_RD_MAIN,
        OP_RD_STAT
    } op_t;

    localparam logic [3:0] OPR_IO  = 4'b1110;

    localparam logic [3:0] OPA_WRM = 4'b0000;
    localparam logic [3:0] OPA_WMP = 4'b0001;
    localparam logic [3:0] OPA_WR0 = 4'b0100;
    localparam logic [3:0] OPA_WR1 = 4'b0101;
    localparam logic [3:0] OPA_WR2 = 4'b0110;
    localparam logic [3:0] OPA_WR3 = 4'b0111;
    localparam logic [3:0] OPA_SBM = 4'b1000;
    localparam logic [3:0] OPA_RDM = 4'b1001;
    localparam logic [3:0] OPA_ADM = 4'b1011;
    localparam logic [3:0] OPA_RD0 = 4'b1100;
    localparam logic [3:0] OPA_RD1 = 4'b1101;
    localparam logic [3:0] OPA_RD2 = 4'b1110;
    localparam logic [3:0] OPA_RD3 = 4'b1111;

    // ROM-side codes (0010, 0011, 1010) fall through to OP_NONE.
    function automatic op_t decode_opa(input logic [3:0] opa, input logic port_en);
        op_t op;
        op = OP_NONE;
        case (opa)
            OPA_WRM:                            op = OP_WR_MAIN;
            OPA_WMP:                            op = port_en ? OP_WR_PORT : OP_NONE;
            OPA_WR0, OPA_WR1, OPA_WR2, OPA_WR3: op = OP_WR_STAT;
            OPA_SBM, OPA_RDM, OPA_ADM:          op = OP_RD_MAIN;
            OPA_RD0, OPA_RD1, OPA_RD2, OPA_RD3: op = OP_RD_STAT;
            default:                            op = OP_NONE;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/mcs4_cycle_timer.sv
// SYNC-driven 8-phase instruction-cycle tracker with an IDLE state.
// SYNC always forces A1 next; a cycle that reaches X3 without SYNC falls back to IDLE.
module mcs4_cycle_timer
    import mcs4_pkg::*;
(
    input  logic   CLK,
    input  logic   RES_N,
    input  logic   SYNC,
    output phase_t PHASE
);

    phase_t phase_q;
    phase_t phase_d;

    always_ff @(posedge CLK or negedge RES_N) begin
        if (!RES_N) begin
            phase_q <= PH_IDLE;
        end else begin
            phase_q <= phase_d;
        end
    end

    always_comb begin
        phase_d = phase_q;
        if (SYNC) begin
            phase_d = PH_A1;
        end else begin
            case (phase_q)
                PH_IDLE: phase_d = PH_IDLE;
                PH_A1:   phase_d = PH_A2;
                PH_A2:   phase_d = PH_A3;
                PH_A3:   phase_d = PH_M1;
                PH_M1:   phase_d = PH_M2;
                PH_M2:   phase_d = PH_X1;
                PH_X1:   phase_d = PH_X2;
                PH_X2:   phase_d = PH_X3;
                PH_X3:   phase_d = PH_IDLE;
                default: phase_d = PH_IDLE;
            endcase
        end
    end

    assign PHASE = phase_q;

endmodule

// File: rtl/mcs4_ram_responder.sv
// 4002-style data RAM / status store answering SRC and I/O instructions on the MCS-4 bus.
// Optional WMP output port enabled by defining MCS4_RAM_OUTPORT_EN.
module mcs4_ram_responder
    import mcs4_pkg::*;
#(
    parameter logic [1:0] CHIP_ID = 2'd0
) (
    input  logic       CLK,
    input  logic       RES_N,
    input  logic       SYNC,
    input  logic       CM_RAM,
    input  logic [3:0] BUS_I,
    output logic [3:0] BUS_O,
    output logic       BUS_OE,
    output logic [3:0] OUT_PORT
);

    phase_t phase;

    mcs4_cycle_timer u_timer (
        .CLK   (CLK),
        .RES_N (RES_N),
        .SYNC  (SYNC),
        .PHASE (phase)
    );

    logic       selected;
    logic [1:0] reg_addr;
    logic [3:0] char_addr;
    logic       src_pend;
    logic [3:0] opr_q;
    op_t        op_q;
    op_t        op_dec;
    logic [1:0] stat_idx;
    logic       wr_go;
    logic [3:0] rd_data;
    logic       rd_valid;

    logic [3:0] main_mem [4][16];
    logic [3:0] stat_mem [4][4];

`ifdef MCS4_RAM_OUTPORT_EN
    assign op_dec = decode_opa(BUS_I, 1'b1);
`else
    assign op_dec = decode_opa(BUS_I, 1'b0);
`endif

    // A SYNC at X2 restarts the cycle, so the data phase is abandoned.
    assign wr_go = (phase == PH_X2) && !SYNC;

    always_ff @(posedge CLK or negedge RES_N) begin
        if (!RES_N) begin
            selected  <= 1'b0;
            reg_addr  <= '0;
            char_addr <= '0;
            src_pend  <= 1'b0;
            opr_q     <= '0;
            op_q      <= OP_NONE;
            stat_idx  <= '0;
        end else begin
            src_pend <= (phase == PH_X2) && CM_RAM;
            if (phase == PH_X2 && CM_RAM) begin
                selected <= (BUS_I[3:2] == CHIP_ID);
                reg_addr <= BUS_I[1:0];
            end
            if (phase == PH_X3 && src_pend) begin
                char_addr <= BUS_I;
            end
            if (phase == PH_M1) begin
                opr_q <= BUS_I;
            end
            if (phase == PH_M2) begin
                op_q     <= (CM_RAM && selected) ? op_dec : OP_NONE;
                stat_idx <= BUS_I[1:0];
            end else if (SYNC || phase == PH_X3) begin
                op_q <= OP_NONE;
            end
        end
    end

    always_comb begin
        rd_data  = '0;
        rd_valid = 1'b0;
        case (op_q)
            OP_RD_MAIN: begin
                rd_data  = main_mem[reg_addr][char_addr];
                rd_valid = 1'b1;
            end
            OP_RD_STAT: begin
                rd_data  = stat_mem[reg_addr][stat_idx];
                rd_valid = 1'b1;
            end
            default: begin
                rd_data  = '0;
                rd_valid = 1'b0;
            end
        endcase
    end

    // Read data is presented for the X2 cycle only; any SYNC at X1 suppresses it.
    always_ff @(posedge CLK or negedge RES_N) begin
        if (!RES_N) begin
            BUS_O  <= '0;
            BUS_OE <= 1'b0;
        end else if (phase == PH_X1 && !SYNC && rd_valid) begin
            BUS_O  <= rd_data;
            BUS_OE <= 1'b1;
        end else begin
            BUS_O  <= '0;
            BUS_OE <= 1'b0;
        end
    end

    always_ff @(posedge CLK or negedge RES_N) begin
        if (!RES_N) begin
            for (int unsigned r = 0; r < 4; r++) begin
                for (int unsigned c = 0; c < 16; c++) begin
                    main_mem[r][c] <= '0;
                end
                for (int unsigned s = 0; s < 4; s++) begin
                    stat_mem[r][s] <= '0;
                end
            end
        end else if (wr_go) begin
            if (op_q == OP_WR_MAIN) begin
                main_mem[reg_addr][char_addr] <= BUS_I;
            end
            if (op_q == OP_WR_STAT) begin
                stat_mem[reg_addr][stat_idx] <= BUS_I;
            end
        end
    end

`ifdef MCS4_RAM_OUTPORT_EN
    logic [3:0] out_port_q;

    always_ff @(posedge CLK or negedge RES_N) begin
        if (!RES_N) begin
            out_port_q <= '0;
        end else if (wr_go && op_q == OP_WR_PORT) begin
            out_port_q <= BUS_I;
        end
    end

    assign OUT_PORT = out_port_q;
`else
    assign OUT_PORT = '0;
`endif

    // The RAM only ever sees a command strobe at M2 during an I/O-group instruction.
    a_io_opr : assert property (@(posedge CLK) disable iff (!RES_N)
        (phase == PH_M2 && CM_RAM) |-> (opr_q == OPR_IO));

endmodule

// File: tb/tb_mcs4_ram_responder.sv
// Scoreboard bench for mcs4_ram_responder (CHIP_ID=2); OUT_PORT expectation follows MCS4_RAM_OUTPORT_EN.
module tb_mcs4_ram_responder;
    import mcs4_pkg::*;

    logic       CLK = 1'b0;
    logic       RES_N = 1'b0;
    logic       SYNC = 1'b0;
    logic       CM_RAM = 1'b0;
    logic [3:0] BUS_I = 4'h0;
    logic [3:0] BUS_O;
    logic       BUS_OE;
    logic [3:0] OUT_PORT;

    always #5 CLK = ~CLK;

    mcs4_ram_responder #(.CHIP_ID(2'd2)) dut (
        .CLK      (CLK),
        .RES_N    (RES_N),
        .SYNC     (SYNC),
        .CM_RAM   (CM_RAM),
        .BUS_I    (BUS_I),
        .BUS_O    (BUS_O),
        .BUS_OE   (BUS_OE),
        .OUT_PORT (OUT_PORT)
    );

    localparam logic [2:0] M_NONE = 3'd0, M_WRM = 3'd1, M_WRS = 3'd2,
                           M_WRP  = 3'd3, M_RDM = 3'd4, M_RDS = 3'd5;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;
    logic [4:0]  sb_q[$];

    logic [3:0] m_main [4][16];
    logic [3:0] m_stat [4][4];
    logic [3:0] m_port;
    logic       m_sel;
    logic [1:0] m_reg;
    logic [3:0] m_char;

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [2:0] m_decode(input logic [3:0] opa);
        if (opa == 4'b0000) return M_WRM;
        if (opa == 4'b0001) begin
`ifdef MCS4_RAM_OUTPORT_EN
            return M_WRP;
`else
            return M_NONE;
`endif
        end
        if (opa[3:2] == 2'b01) return M_WRS;
        if (opa == 4'b1000 || opa == 4'b1001 || opa == 4'b1011) return M_RDM;
        if (opa[3:2] == 2'b11) return M_RDS;
        return M_NONE;
    endfunction

    task automatic m_reset();
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 16; c++) m_main[r][c] = 4'h0;
            for (int s = 0; s < 4; s++) m_stat[r][s] = 4'h0;
        end
        m_port = 4'h0;
        m_sel  = 1'b0;
        m_reg  = 2'd0;
        m_char = 4'h0;
    endtask

    // One bus phase: inputs change just after the rising edge, outputs are sampled at the falling edge.
    task automatic ph(input logic s, input logic cm, input logic [3:0] b);
        @(posedge CLK);
        #1;
        SYNC   = s;
        CM_RAM = cm;
        BUS_I  = b;
        @(negedge CLK);
    endtask

    task automatic sb_check(input string tag);
        logic [4:0] e;
        chk({tag, "/sb_depth"}, 8'(sb_q.size()), 8'd1);
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            chk({tag, "/oe"},   8'(BUS_OE), 8'(e[4]));
            chk({tag, "/data"}, 8'(BUS_O),  8'(e[3:0]));
        end
    endtask

    // Full instruction cycle starting at A1; ends in X3 with SYNC high so the next call begins at A1.
    task automatic io_cycle(input string tag, input logic [3:0] opr, input logic [3:0] opa,
                            input logic cm_m2, input logic cm_x2, input logic [3:0] x2,
                            input logic [3:0] x3, input logic abort);
        logic [2:0] op;
        logic [1:0] idx;
        ph(1'b0, 1'b0, 4'h0);
        chk({tag, "/phase_a1"}, 8'(dut.phase), 8'(PH_A1));
        ph(1'b0, 1'b0, 4'h0);
        ph(1'b0, 1'b0, 4'h0);
        ph(1'b0, 1'b0, opr);
        ph(1'b0, cm_m2, opa);
        op  = (cm_m2 && m_sel) ? m_decode(opa) : M_NONE;
        idx = opa[1:0];
        chk({tag, "/oe_m2"}, 8'(BUS_OE), 8'd0);
        if (abort) begin
            ph(1'b1, 1'b0, 4'h0);
            sb_q.push_back(5'b0);
            ph(1'b0, 1'b0, 4'h0);
            chk({tag, "/restart_a1"}, 8'(dut.phase), 8'(PH_A1));
            sb_check({tag, "/abort"});
            repeat (6) ph(1'b0, 1'b0, 4'h0);
            ph(1'b1, 1'b0, 4'h0);
            chk({tag, "/phase_x3"}, 8'(dut.phase), 8'(PH_X3));
            return;
        end
        ph(1'b0, 1'b0, 4'h0);
        if (op == M_RDM)      sb_q.push_back({1'b1, m_main[m_reg][m_char]});
        else if (op == M_RDS) sb_q.push_back({1'b1, m_stat[m_reg][idx]});
        else                  sb_q.push_back(5'b0);
        ph(1'b0, cm_x2, x2);
        sb_check({tag, "/x2"});
        if (op == M_WRM) m_main[m_reg][m_char] = x2;
        if (op == M_WRS) m_stat[m_reg][idx] = x2;
        if (op == M_WRP) m_port = x2;
        if (cm_x2) begin
            m_sel = (x2[3:2] == 2'd2);
            m_reg = x2[1:0];
        end
        ph(1'b1, 1'b0, x3);
        if (cm_x2) m_char = x3;
        chk({tag, "/oe_x3"},    8'(BUS_OE),   8'd0);
        chk({tag, "/out_port"}, 8'(OUT_PORT), 8'(m_port));
        chk({tag, "/phase_x3"}, 8'(dut.phase), 8'(PH_X3));
    endtask

    task automatic src(input string tag, input logic [3:0] hi, input logic [3:0] lo);
        io_cycle(tag, 4'h2, 4'h1, 1'b0, 1'b1, hi, lo, 1'b0);
    endtask

    task automatic io(input string tag, input logic [3:0] opa, input logic [3:0] data);
        io_cycle(tag, 4'hE, opa, 1'b1, 1'b0, data, 4'h0, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        m_reset();
        repeat (3) @(negedge CLK);
        chk("reset/phase",    8'(dut.phase), 8'(PH_IDLE));
        chk("reset/bus_o",    8'(BUS_O),     8'd0);
        chk("reset/bus_oe",   8'(BUS_OE),    8'd0);
        chk("reset/out_port", 8'(OUT_PORT),  8'd0);
        RES_N = 1'b1;

        // Free-running cycle without a closing SYNC falls back to IDLE.
        ph(1'b1, 1'b0, 4'h0);
        for (int i = 0; i < 8; i++) begin
            ph(1'b0, 1'b0, 4'h0);
            chk($sformatf("walk/phase%0d", i), 8'(dut.phase), 8'(i + 1));
            chk($sformatf("walk/oe%0d", i),    8'(BUS_OE),    8'd0);
        end
        ph(1'b0, 1'b0, 4'h0);
        chk("walk/idle", 8'(dut.phase), 8'(PH_IDLE));
        ph(1'b0, 1'b0, 4'h0);
        chk("walk/idle_hold", 8'(dut.phase), 8'(PH_IDLE));
        ph(1'b1, 1'b0, 4'h0);

        src("src_c2", 4'b1001, 4'h5);
        io("wrm_a", OPA_WRM, 4'hA);
        io("rdm_a", OPA_RDM, 4'h0);

        src("src_c0", 4'b0001, 4'h5);
        io("wrm_other", OPA_WRM, 4'h7);
        io("rdm_other", OPA_RDM, 4'h0);

        src("src_c2b", 4'b1001, 4'h5);
        io("rdm_kept", OPA_RDM, 4'h0);
        io("wr2", OPA_WR2, 4'h3);
        io("rd2", OPA_RD2, 4'h0);
        io("rd1", OPA_RD1, 4'h0);
        io("adm", OPA_ADM, 4'h0);
        io("rom_op", 4'b1010, 4'h0);
        io("wmp", OPA_WMP, 4'hC);

        // WRM whose data nibble also carries a new SRC address.
        io_cycle("collide", 4'hE, OPA_WRM, 1'b1, 1'b1, 4'b1011, 4'h3, 1'b0);
        io("rdm_new_addr", OPA_RDM, 4'h0);
        src("src_back", 4'b1001, 4'h5);
        io("rdm_collide", OPA_RDM, 4'h0);

        io_cycle("abort_wrm", 4'hE, OPA_WRM, 1'b1, 1'b0, 4'h6, 4'h0, 1'b1);
        io("rdm_after_abort", OPA_RDM, 4'h0);

        // Reset pulse landing in M2 of an RDM.
        ph(1'b0, 1'b0, 4'h0);
        ph(1'b0, 1'b0, 4'h0);
        ph(1'b0, 1'b0, 4'h0);
        ph(1'b0, 1'b0, 4'hE);
        ph(1'b0, 1'b1, OPA_RDM);
        RES_N = 1'b0;
        #1;
        chk("midrst/phase",    8'(dut.phase), 8'(PH_IDLE));
        chk("midrst/bus_o",    8'(BUS_O),     8'd0);
        chk("midrst/bus_oe",   8'(BUS_OE),    8'd0);
        chk("midrst/out_port", 8'(OUT_PORT),  8'd0);
        SYNC   = 1'b0;
        CM_RAM = 1'b0;
        BUS_I  = 4'h0;
        m_reset();
        @(negedge CLK);
        RES_N = 1'b1;
        ph(1'b1, 1'b0, 4'h0);
        io("rdm_unselected", OPA_RDM, 4'h0);
        src("src_post_rst", 4'b1001, 4'h5);
        io("rdm_cleared", OPA_RDM, 4'h0);
        io("rd2_cleared", OPA_RD2, 4'h0);

        chk("sb/empty", 8'(sb_q.size()), 8'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
